// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch front end: PC, imem request channel, prefetch FIFO, redirect.
// Credit-based issue keeps in-flight requests plus buffered entries within DEPTH, so the FIFO never overflows.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   pc_mem_q    [DEPTH];

  logic [CW:0]   credit_used;
  logic          req_fire;
  logic          push;
  logic          pop;
  logic [CW-1:0] rsp_dec;

  assign credit_used = {1'b0, inflight_q} + {1'b0, count_q};
  // Gated by reset so the request line is quiet while reset is held.
  assign imem_req_valid = rst && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign push           = imem_rsp_valid && !redirect_valid && (drop_q == '0);
  assign instr_valid    = (count_q != '0);
  assign pop            = instr_valid && instr_ready;
  assign instr          = instr_valid ? instr_mem_q[rd_ptr_q] : 32'h0;
  assign instr_pc       = instr_valid ? pc_mem_q[rd_ptr_q] : 32'h0;
  assign rsp_dec        = {{(CW-1){1'b0}}, imem_rsp_valid};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (redirect_valid) begin
      // Every outstanding response, including one arriving now, gets discarded.
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      rsp_pc_d   = {redirect_pc[31:2], 2'b00};
      inflight_d = inflight_q - rsp_dec;
      drop_d     = inflight_q - rsp_dec;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      inflight_d = inflight_q + {{(CW-1){1'b0}}, req_fire} - rsp_dec;
      if (imem_rsp_valid && (drop_q != '0)) begin
        drop_d = drop_q - 1'b1;
      end
      if (push) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_rsp_data;
      pc_mem_q[wr_ptr_q]    <= rsp_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed bench for fetch_stage with a fixed-latency in-order memory model.
module tb_fetch_stage;

  typedef struct { int due; logic [31:0] addr; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  int    lat      = 1;
  int    acc_cnt  = 0;
  pend_t pend[$];
  ent_t  outq[$];

  fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] img(input logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'hDEAD_0000;
  endfunction

  function automatic logic [31:0] out_pc(input int i);
    if (i < outq.size()) return outq[i].pc;
    return 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] out_data(input int i);
    if (i < outq.size()) return outq[i].data;
    return 32'hxxxx_xxxx;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes before the edge, then drive the memory response for the new cycle.
  task automatic step();
    pend_t p;
    #2;
    if (imem_req_valid && imem_req_ready) begin
      p.due  = cyc + lat;
      p.addr = imem_req_addr;
      pend.push_back(p);
      acc_cnt++;
    end
    if (rst && instr_valid && instr_ready) outq.push_back('{pc: instr_pc, data: instr});
    @(posedge clk);
    #1;
    cyc++;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      p = pend.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = img(p.addr);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    step();
    step();
    pend.delete();
    outq.delete();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    acc_cnt = 0;
    rst = 1'b1;
    cyc = 0;
    #1;
  endtask

  initial begin
    rst = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b1;
    @(posedge clk);
    #1;

    // Reset values while reset is held
    step();
    step();
    chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);

    // Straight-line fetch, 1-cycle memory
    lat = 1;
    do_reset();
    chk("sl_req_valid_c0", {31'h0, imem_req_valid}, 32'h1);
    chk("sl_req_addr_c0", imem_req_addr, 32'h0);
    step();
    chk("sl_req_addr_c1", imem_req_addr, 32'h4);
    chk("sl_instr_valid_c1", {31'h0, instr_valid}, 32'h0);
    step();
    chk("sl_instr_valid_c2", {31'h0, instr_valid}, 32'h1);
    chk("sl_instr_pc_c2", instr_pc, 32'h0);
    chk("sl_instr_c2", instr, img(32'h0));
    for (int k = 3; k < 9; k++) begin
      step();
      chk("sl_valid", {31'h0, instr_valid}, 32'h1);
      chk("sl_pc", instr_pc, 32'((k - 2) * 4));
      chk("sl_instr", instr, img(32'((k - 2) * 4)));
    end

    // Backpressure: decode stalls for 10 cycles
    do_reset();
    instr_ready = 1'b0;
    for (int k = 0; k < 10; k++) step();
    chk("bp_accepted", 32'(acc_cnt), 32'd4);
    chk("bp_req_valid", {31'h0, imem_req_valid}, 32'h0);
    chk("bp_instr_valid", {31'h0, instr_valid}, 32'h1);
    instr_ready = 1'b1;
    for (int k = 0; k < 6; k++) step();
    chk("bp_out_count", 32'(outq.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      chk("bp_pc", out_pc(i), 32'(i * 4));
      chk("bp_data", out_data(i), img(32'(i * 4)));
    end

    // Memory stall: random acceptance, 3-cycle latency
    lat = 3;
    do_reset();
    for (int k = 0; k < 80; k++) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      step();
    end
    imem_req_ready = 1'b1;
    chk("ms_enough", {31'h0, outq.size() >= 8}, 32'h1);
    for (int i = 0; i < outq.size(); i++) begin
      chk("ms_pc", out_pc(i), 32'(i * 4));
      chk("ms_data", out_data(i), img(32'(i * 4)));
    end

    // Redirect with 3 responses in flight
    lat = 3;
    do_reset();
    step();
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    #1;
    chk("rd_req_valid_n", {31'h0, imem_req_valid}, 32'h0);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("rd_instr_valid_n1", {31'h0, instr_valid}, 32'h0);
    chk("rd_req_valid_n1", {31'h0, imem_req_valid}, 32'h1);
    chk("rd_req_addr_n1", imem_req_addr, 32'h0000_0100);
    for (int k = 0; k < 10; k++) step();
    chk("rd_first_pc", out_pc(0), 32'h0000_0100);
    chk("rd_first_data", out_data(0), img(32'h0000_0100));
    chk("rd_second_pc", out_pc(1), 32'h0000_0104);

    // Redirect coincident with response and pop, then unaligned second redirect
    lat = 1;
    do_reset();
    for (int k = 0; k < 4; k++) step();
    chk("ed_pre_rsp", {31'h0, imem_rsp_valid}, 32'h1);
    chk("ed_pre_valid", {31'h0, instr_valid}, 32'h1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0500;
    step();
    redirect_pc    = 32'h0000_0203;
    #1;
    chk("ed_req_valid_2nd", {31'h0, imem_req_valid}, 32'h0);
    step();
    redirect_valid = 1'b0;
    outq.delete();
    #1;
    chk("ed_instr_valid", {31'h0, instr_valid}, 32'h0);
    chk("ed_req_addr", imem_req_addr, 32'h0000_0200);
    for (int k = 0; k < 8; k++) step();
    for (int i = 0; i < 4; i++) begin
      chk("ed_pc", out_pc(i), 32'h0000_0200 + 32'(i * 4));
      chk("ed_data", out_data(i), img(32'h0000_0200 + 32'(i * 4)));
    end

    // Address wrap
    do_reset();
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    outq.delete();
    for (int k = 0; k < 8; k++) step();
    chk("wr_pc0", out_pc(0), 32'hFFFF_FFFC);
    chk("wr_data0", out_data(0), img(32'hFFFF_FFFC));
    chk("wr_pc1", out_pc(1), 32'h0000_0000);
    chk("wr_data1", out_data(1), img(32'h0000_0000));
    chk("wr_pc2", out_pc(2), 32'h0000_0004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch front end for the pipelined RISC-V core, directly upstream of the IF/ID pipeline register. Owns the program counter and issues word-aligned reads to instruction memory over a valid/ready request channel. Buffers in-order responses in a small prefetch FIFO and presents them to decode with a valid/ready handshake. Supports a redirect (branch/jump) that flushes the buffer and discards in-flight responses.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset
- DEPTH, 4: prefetch FIFO entries and max in-flight requests combined; power of two, ≥2

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  one clock; reset is asynchronous and active-low
- imem_req_valid  out  1  request to instruction memory
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  32  word-aligned fetch address
- imem_rsp_valid  in  1  response data valid; in order, ≥1 cycle after acceptance, never stalled
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  redirect fetch, from execute
- redirect_pc  in  32  new fetch address; bits [1:0] ignored, treated as 0
- instr_valid  out  1  FIFO head valid to decode
- instr_ready  in  1  decode accepts head
- instr  out  32  head instruction
- instr_pc  out  32  address of head instruction

## Operation
- State: fetch_pc (next request address), rsp_pc (address of next accepted response), inflight count, drop count, FIFO (instr + pc per entry), FIFO count. Counters are $clog2(DEPTH+1) bits.
- Issue rule: imem_req_valid = !redirect_valid && (inflight + fifo_count < DEPTH). inflight includes responses marked for drop. No overflow is therefore possible.
- Request accepted (valid && ready): fetch_pc += 4 (mod 2^32), inflight += 1.
- Response: inflight -= 1.
  - If drop > 0: drop -= 1, data discarded.
  - Otherwise: push {imem_rsp_data, rsp_pc}, rsp_pc += 4.
- Pop: instr_valid && instr_ready removes head. Push and pop in the same cycle are allowed at any count, including full.
- Redirect cycle, priority over everything except reset:
  - FIFO cleared; a same-cycle pop is a don't-care.
  - fetch_pc and rsp_pc ← {redirect_pc[31:2], 2'b00}.
  - drop ← inflight − (imem_rsp_valid ? 1 : 0), i.e. every still-outstanding response is discarded. A response arriving in the redirect cycle is itself discarded.
  - No request is issued.
- Redirects in back-to-back cycles are legal; the last one wins, and drop is recomputed each time.
- instr and instr_pc are don't-care when instr_valid = 0.

## Timing
- Reset (asynchronous assert):
  - fetch_pc and rsp_pc = RESET_PC; inflight, drop and fifo_count = 0.
  - Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
- Release: imem_req_valid may assert in the first cycle after release.
- Response at cycle T → instr_valid from T+1. The FIFO is registered, with no fall-through.
- With 1-cycle memory and ready held high: request accepted at C, response at C+1, instr_valid at C+2.
- Steady-state throughput is one instruction per cycle when DEPTH ≥ memory latency + 1.
- Redirect at cycle N:
  - instr_valid=0 at N+1.
  - First new request at N+1 if there is credit.
  - With 1-cycle memory, first redirected instruction valid at N+3.
- Reset mid-operation: all in-flight responses are abandoned. The memory model must also be reset.

## Test plan
- Reset/straight-line: RESET_PC=0, 1-cycle memory, instr_ready=1 → requests 0x0,0x4,0x8…; instr_pc 0x0 at cycle 2, then +4 per cycle; instr matches the memory image.
- Backpressure: instr_ready=0 for 10 cycles, DEPTH=4 → exactly 4 requests accepted, then imem_req_valid=0. Release ready → 0x0,0x4,0x8,0xC emitted consecutively, with no loss or duplication.
- Memory stall: imem_req_ready toggling randomly, 3-cycle latency → instr_pc sequence contiguous, no gaps.
- Redirect with in-flight: 3-cycle latency, 3 outstanding, redirect_pc=0x100 → 3 responses dropped; next instr_pc=0x100 with instr=mem[0x40].
- Redirect edge cases:
  - Redirect coincident with a response and a pop, then a second redirect next cycle to 0x203 → only 0x200,0x204… emitted.
  - Unaligned low bits are cleared.
- Wrap: redirect_pc=0xFFFF_FFFC → instr_pc 0xFFFF_FFFC then 0x0000_0000.
